// File: rtl/emu_sched_pkg.sv
// rtl/emu_sched_pkg.sv - shared types, state encoding and helpers for the emulator clock scheduler
package emu_sched_pkg;

  localparam int DT_WIDTH   = 16;
  localparam int TIME_WIDTH = 40;

  typedef logic [DT_WIDTH-1:0]   dt_t;
  typedef logic [TIME_WIDTH-1:0] time_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic dt_t clamp1(input dt_t x);
    return (x == '0) ? dt_t'(1) : x;
  endfunction

endpackage

// File: rtl/dt_min_tree.sv
// rtl/dt_min_tree.sv - balanced combinational minimum over n+1 timestep candidates
module dt_min_tree #(
  parameter int n        = 2,
  parameter int dt_width = 16
) (
  input  logic [dt_width-1:0] vals_i [n+1],
  output logic [dt_width-1:0] min_o
);

  localparam int LEAVES = n + 1;
  localparam int LVLS   = $clog2(LEAVES);
  localparam int P      = 1 << LVLS;

  // Unused leaves are padded with all-ones so they never win the comparison.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic [dt_width-1:0] v [P >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < P; i++) begin : g_in
        if (i < LEAVES) begin : g_real
          assign v[i] = vals_i[i];
        end else begin : g_pad
          assign v[i] = '1;
        end
      end
    end else begin : g_node
      for (genvar i = 0; i < (P >> l); i++) begin : g_cmp
        assign v[i] = (g_lvl[l-1].v[2*i] <= g_lvl[l-1].v[2*i+1]) ?
                      g_lvl[l-1].v[2*i] : g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign min_o = g_lvl[LVLS].v[0];

endmodule

// File: rtl/emu_clk_sched.sv
// rtl/emu_clk_sched.sv - picks the emulation timestep to the next oscillator edge and advances emulated time
module emu_clk_sched
  import emu_sched_pkg::*;
#(
  parameter int n          = 2,
  parameter int dt_width   = 16,
  parameter int time_width = 40
) (
  input  logic                         emu_clk,
  input  logic                         emu_rst_n,
  input  logic                         emu_stall,
  input  logic [dt_width-1:0]          dt_max,
  input  logic [n-1:0]                 osc_en,
  input  logic [n-1:0][dt_width-1:0]   osc_tlo,
  input  logic [n-1:0][dt_width-1:0]   osc_thi,
  output logic                         clk_vals [n],
  output logic [dt_width-1:0]          emu_dt,
  output logic [time_width-1:0]        emu_time
);

  typedef logic [dt_width-1:0]   dtw_t;
  typedef logic [time_width-1:0] tw_t;

  function automatic dtw_t clamp_dt(input dtw_t x);
    return (x == '0) ? dtw_t'(1) : x;
  endfunction

  state_e       state_q, state_d;
  dtw_t         rem_q [n];
  dtw_t         rem_d [n];
  dtw_t         rem_dec [n];
  logic [n-1:0] clk_q, clk_d;
  dtw_t         dt_q, dt_d;
  tw_t          time_q, time_d;

  dtw_t         cap;
  dtw_t         req [n+1];
  dtw_t         dt_min;

  assign cap = clamp_dt(dt_max);

  // A disabled oscillator contributes the cap, so it never shortens the step.
  always_comb begin
    req[0] = cap;
    for (int k = 0; k < n; k++) begin
      req[k+1] = osc_en[k] ? rem_q[k] : cap;
    end
  end

  dt_min_tree #(
    .n        (n),
    .dt_width (dt_width)
  ) u_dt_min_tree (
    .vals_i (req),
    .min_o  (dt_min)
  );

  always_comb begin
    for (int k = 0; k < n; k++) begin
      rem_dec[k] = rem_q[k] - dt_min;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    clk_d   = clk_q;
    dt_d    = dt_q;
    time_d  = time_q;
    unique case (state_q)
      INIT: begin
        for (int k = 0; k < n; k++) begin
          rem_d[k] = clamp_dt(osc_tlo[k]);
        end
        dt_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        if (emu_stall) begin
          dt_d = '0;
        end else begin
          dt_d   = dt_min;
          time_d = time_q + tw_t'(dt_min);
          for (int k = 0; k < n; k++) begin
            if (!osc_en[k]) begin
              clk_d[k] = 1'b0;
              rem_d[k] = clamp_dt(osc_tlo[k]);
            end else if (rem_dec[k] == '0) begin
              clk_d[k] = ~clk_q[k];
              rem_d[k] = clamp_dt(clk_q[k] ? osc_tlo[k] : osc_thi[k]);
            end else begin
              rem_d[k] = rem_dec[k];
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q <= INIT;
      rem_q   <= '{default: '0};
      clk_q   <= '0;
      dt_q    <= '0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      clk_q   <= clk_d;
      dt_q    <= dt_d;
      time_q  <= time_d;
    end
  end

  always_comb begin
    for (int k = 0; k < n; k++) begin
      clk_vals[k] = clk_q[k];
    end
  end

  assign emu_dt   = dt_q;
  assign emu_time = time_q;

endmodule

// File: tb/tb_emu_clk_sched.sv
// tb/tb_emu_clk_sched.sv - randomized and directed bench against an absolute-edge-time reference model
module tb_emu_clk_sched;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int TW = 40;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 stall = 1'b0;
  logic [DW-1:0]        dt_max = '0;
  logic [N-1:0]         en = '0;
  logic [N-1:0][DW-1:0] tlo = '0;
  logic [N-1:0][DW-1:0] thi = '0;
  logic                 clk_vals [N];
  logic [DW-1:0]        emu_dt;
  logic [TW-1:0]        emu_time;

  logic [0:0]           b_en = 1'b1;
  logic [0:0][DW-1:0]   b_tlo = '0;
  logic [0:0][DW-1:0]   b_thi = '0;
  logic [DW-1:0]        b_dt_max = '0;
  logic                 b_clk_vals [1];
  logic [DW-1:0]        b_dt;
  logic [7:0]           b_time;

  emu_clk_sched #(.n(N), .dt_width(DW), .time_width(TW)) dut (
    .emu_clk   (clk),
    .emu_rst_n (rst_n),
    .emu_stall (stall),
    .dt_max    (dt_max),
    .osc_en    (en),
    .osc_tlo   (tlo),
    .osc_thi   (thi),
    .clk_vals  (clk_vals),
    .emu_dt    (emu_dt),
    .emu_time  (emu_time)
  );

  emu_clk_sched #(.n(1), .dt_width(DW), .time_width(8)) dut_w (
    .emu_clk   (clk),
    .emu_rst_n (rst_n),
    .emu_stall (1'b0),
    .dt_max    (b_dt_max),
    .osc_en    (b_en),
    .osc_tlo   (b_tlo),
    .osc_thi   (b_thi),
    .clk_vals  (b_clk_vals),
    .emu_dt    (b_dt),
    .emu_time  (b_time)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: emulated time T and the absolute time of each oscillator's next edge.
  bit     m_init;
  longint T;
  longint nxt [N];
  bit     lvl [N];
  longint mdt;

  function automatic longint c1(input longint x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic model_reset();
    m_init = 1'b1;
    T      = 0;
    mdt    = 0;
    for (int k = 0; k < N; k++) begin
      lvl[k] = 1'b0;
      nxt[k] = 0;
    end
  endtask

  task automatic model_step();
    longint cap;
    if (m_init) begin
      for (int k = 0; k < N; k++) nxt[k] = T + c1(longint'(tlo[k]));
      mdt    = 0;
      m_init = 1'b0;
    end else if (stall) begin
      mdt = 0;
    end else begin
      cap = c1(longint'(dt_max));
      mdt = cap;
      for (int k = 0; k < N; k++)
        if (en[k] && (nxt[k] - T) < mdt) mdt = nxt[k] - T;
      T = T + mdt;
      for (int k = 0; k < N; k++) begin
        if (!en[k]) begin
          lvl[k] = 1'b0;
          nxt[k] = T + c1(longint'(tlo[k]));
        end else if (nxt[k] == T) begin
          lvl[k] = ~lvl[k];
          nxt[k] = T + c1(longint'(lvl[k] ? thi[k] : tlo[k]));
        end
      end
    end
  endtask

  task automatic compare_all();
    check("dt",   64'(emu_dt),   64'(mdt));
    check("time", 64'(emu_time), 64'(T) & 64'hFF_FFFF_FFFF);
    check("clk0", 64'(clk_vals[0]), 64'(lvl[0]));
    check("clk1", 64'(clk_vals[1]), 64'(lvl[1]));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_dt",   64'(emu_dt),   64'd0);
    check("rst_time", 64'(emu_time), 64'd0);
    check("rst_clk0", 64'(clk_vals[0]), 64'd0);
    check("rst_clk1", 64'(clk_vals[1]), 64'd0);
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  int exp_dt1 [3]  = '{3, 2, 3};
  int exp_t1  [3]  = '{3, 5, 8};
  int exp_c01 [3]  = '{0, 1, 1};
  int exp_c11 [3]  = '{1, 0, 1};
  int exp_bt  [3]  = '{100, 200, 44};
  int exp_bc  [3]  = '{1, 0, 1};
  int exp_dt2 [3]  = '{4, 4, 2};
  int exp_c02 [3]  = '{0, 0, 1};

  initial begin
    #1;
    // Two oscillators with unequal periods; wrap instance runs alongside.
    dt_max = 16'd100; en = 2'b11;
    tlo[0] = 16'd5; thi[0] = 16'd5; tlo[1] = 16'd3; thi[1] = 16'd2;
    b_tlo[0] = 16'd100; b_thi[0] = 16'd100; b_dt_max = 16'd1000;
    do_reset();
    check("w_init_dt", 64'(b_dt), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("s1_dt",   64'(emu_dt),      64'(exp_dt1[c]));
      check("s1_time", 64'(emu_time),    64'(exp_t1[c]));
      check("s1_clk0", 64'(clk_vals[0]), 64'(exp_c01[c]));
      check("s1_clk1", 64'(clk_vals[1]), 64'(exp_c11[c]));
      check("w_time",  64'(b_time),      64'(exp_bt[c]));
      check("w_clk",   64'(b_clk_vals[0]), 64'(exp_bc[c]));
    end

    // Stall mid-run freezes everything but forces dt to 0.
    repeat (2) step();
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (4) step();

    // Timestep capped below the half-period.
    en = 2'b01; tlo[0] = 16'd10; thi[0] = 16'd10; dt_max = 16'd4;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      check("s2_dt",   64'(emu_dt),      64'(exp_dt2[c]));
      check("s2_clk0", 64'(clk_vals[0]), 64'(exp_c02[c]));
    end
    check("s2_time", 64'(emu_time), 64'd10);

    // One oscillator disabled.
    tlo[0] = 16'd5; thi[0] = 16'd5; dt_max = 16'd100;
    do_reset();
    repeat (6) step();

    // Zero half-periods and zero cap behave as one.
    tlo = '0; thi = '0; dt_max = '0;
    do_reset();
    repeat (4) step();
    check("s5_dt", 64'(emu_dt), 64'd1);

    // Asynchronous reset asserted between edges.
    en = 2'b11; tlo[0] = 16'd4; thi[0] = 16'd3; tlo[1] = 16'd2; thi[1] = 16'd6; dt_max = 16'd50;
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_dt",   64'(emu_dt),   64'd0);
    check("arst_time", 64'(emu_time), 64'd0);
    check("arst_clk0", 64'(clk_vals[0]), 64'd0);
    check("arst_clk1", 64'(clk_vals[1]), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step();
    check("arst_init_dt", 64'(emu_dt), 64'd0);

    // Random enables, periods, caps and stalls, with mid-flight period changes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < N; k++) begin
          tlo[k] = DW'($urandom_range(0, 9));
          thi[k] = DW'($urandom_range(0, 9));
        end
      end
      if ($urandom_range(0, 5) == 0) en = N'($urandom);
      if ($urandom_range(0, 9) == 0) dt_max = DW'($urandom_range(0, 12));
      stall = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        stall = 1'b0;
        do_reset();
      end else begin
        step();
      end
    end
    stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/emu_clk_sched.md
Name: emu_clk_sched

Overview:
- Scheduler stage directly upstream of the emulator clock generator.
- Runs on emu_clk and models n oscillators, each with a programmable low/high half-period in emulated time units.
- Every emu_clk cycle it selects the emulation timestep as the smallest time to the next oscillator edge, capped at dt_max.
- It advances emulated time and produces registered clk_vals[n]. The clock generator samples clk_vals mid-cycle and gates them into the per-oscillator clocks.

Parameters:
- n, 2, number of oscillators (≥1)
- dt_width, 16, width of timestep, half-period and remaining-time values
- time_width, 40, width of emulated-time accumulator

Ports:
- emu_clk  in  1  emulator clock; all state updates on its rising edge
- emu_rst_n  in  1  asynchronous active-low reset
- emu_stall  in  1  hold: no time advance while high
- dt_max  in  dt_width  upper bound on timestep; 0 is treated as 1
- osc_en  in  n  per-oscillator enable
- osc_tlo  in  n×dt_width  low half-period per oscillator; 0 is treated as 1
- osc_thi  in  n×dt_width  high half-period per oscillator; 0 is treated as 1
- clk_vals  out  n  registered oscillator levels, unpacked array [n]
- emu_dt  out  dt_width  registered timestep applied at the last edge
- emu_time  out  time_width  registered emulated time

Behaviour:
- Reset (async assert, sync release):
  - state=INIT; clk_vals=all 0; emu_dt=0; emu_time=0.
  - rem[k]=0 for every k.
- FSM states are INIT and RUN.
- INIT, one cycle, stall ignored:
  - rem[k] <= max(osc_tlo[k],1) for all k.
  - emu_dt <= 0; emu_time and clk_vals are held.
  - Next state is RUN.
- RUN with emu_stall=1: emu_dt <= 0; all other state is held.
- RUN with emu_stall=0:
  - cap = max(dt_max,1).
  - req[k] = rem[k] if osc_en[k] else cap.
  - dt = min(cap, req[0..n-1]).
  - emu_dt <= dt.
  - emu_time <= emu_time + dt, wrapping modulo 2^time_width.
  - Enabled k:
    - r = rem[k] - dt. Always ≥0, since dt ≤ rem[k].
    - If r==0: clk_vals[k] toggles; rem[k] <= max(next level ? osc_thi[k] : osc_tlo[k], 1).
    - Otherwise: rem[k] <= r.
  - Disabled k: clk_vals[k] <= 0; rem[k] <= max(osc_tlo[k],1). On re-enable, the first rising edge comes tlo after the enable cycle.
- Simultaneous edges: every oscillator whose r reaches 0 toggles on the same emu_clk edge.
- Latency: clk_vals, emu_dt and emu_time all update on the same emu_clk edge. No combinational path exists from inputs to outputs.
- Period changes: a new osc_tlo/osc_thi value takes effect at the next reload only. An in-flight rem is not altered.
- Reset mid-operation: state returns to INIT immediately, asynchronously.
- dt is never 0 in RUN without stall, which guarantees forward progress.

Decomposition:
- Shared package emu_sched_pkg:
  - dt_t / time_t typedefs derived from dt_width / time_width.
  - State enum {INIT, RUN}.
  - Function clamp1(x) = (x==0) ? 1 : x.
- Sub-module dt_min_tree (parameters n, dt_width): combinational minimum of n+1 dt_t inputs, implemented as a balanced tree.

Test Plan:
- n=2, osc0 tlo=thi=5, osc1 tlo=3 thi=2, dt_max=100, all enabled, no stall. Cycles after INIT:
  - c1: dt=3, time=3, clk_vals={0,1}
  - c2: dt=2, time=5, clk_vals={1,0}
  - c3: dt=3, time=8, clk_vals={1,1}
- n=1, tlo=10, dt_max=4 → emu_dt sequence 4,4,2; clk_vals[0] rises only on the third cycle; time=10.
- osc1 disabled, osc0 tlo=thi=5 → dt=5 every cycle; clk_vals[0] toggles every cycle; clk_vals[1] stays 0.
- Stall held for 3 cycles mid-run → emu_dt=0 during stall; emu_time and clk_vals frozen; sequence resumes exactly where it left off.
- osc_tlo=0, osc_thi=0, dt_max=0 → dt=1 per cycle and clk_vals[0] toggles every cycle.
- Wrap and reset cases:
  - time_width=8, single osc tlo=thi=100: emu_time reads 100, 200, 44 (wrap).
  - Assert emu_rst_n low mid-cycle: outputs clear immediately (async), then one INIT cycle with emu_dt=0.
